// File: rtl/fft_bin_power_peak_if.sv
// Bus bundle for fft_bin_power_peak.
//   master : upstream driver of the bin stream; observes power and peak results.
//   slave  : the post-processor; consumes bins and produces power/peak results.
// Signals:
//   in_re/in_im/in_valid           signed complex bin, one per valid cycle
//   pwr_out/pwr_valid/bin_idx/sop/eop   per-bin power with frame markers
//   peak_idx/peak_pwr/peak_valid   peak of the last completed frame
interface fft_bin_power_peak_if #(
   parameter int DATA_WIDTH = 16,
   parameter int FFT_LENGTH = 16
);
   localparam int IDX_W = $clog2(FFT_LENGTH);

   logic signed [DATA_WIDTH-1:0]   in_re;
   logic signed [DATA_WIDTH-1:0]   in_im;
   logic                           in_valid;
   logic        [2*DATA_WIDTH-1:0] pwr_out;
   logic                           pwr_valid;
   logic        [IDX_W-1:0]        bin_idx;
   logic                           sop;
   logic                           eop;
   logic        [IDX_W-1:0]        peak_idx;
   logic        [2*DATA_WIDTH-1:0] peak_pwr;
   logic                           peak_valid;

   modport master (
      output in_re, in_im, in_valid,
      input  pwr_out, pwr_valid, bin_idx, sop, eop, peak_idx, peak_pwr, peak_valid
   );

   modport slave (
      input  in_re, in_im, in_valid,
      output pwr_out, pwr_valid, bin_idx, sop, eop, peak_idx, peak_pwr, peak_valid
   );
endinterface

// File: rtl/fft_bin_power_peak.sv
// Streaming bin power + per-frame peak finder for natural-order FFT output.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fft_bin_power_peak_if.slave: bin stream in, power/peak results out
// Power path: 2 register stages (squares, then sum); pwr_valid follows
// in_valid by exactly 2 cycles, gaps included. Peak tracker is a small FSM
// that watches the registered power stream and pulses peak_valid the cycle
// after eop.
module fft_bin_power_peak #(
   parameter int DATA_WIDTH = 16,
   parameter int FFT_LENGTH = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   fft_bin_power_peak_if.slave bus
);
   localparam int IDX_W  = $clog2(FFT_LENGTH);
   localparam int PW     = 2*DATA_WIDTH;
   localparam int STAGES = 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_LENGTH-1);

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             sop;
      logic             eop;
   } tag_t;

   typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

   logic [IDX_W-1:0]     cnt;
   logic [STAGES:1]      vld_pipe;
   tag_t                 tag1;
   logic signed [PW-1:0] re_x, im_x;
   logic signed [PW-1:0] prod_re, prod_im;

   state_t               state;
   logic [PW-1:0]        max_pwr;
   logic [IDX_W-1:0]     max_idx;
   logic                 take;
   logic [PW-1:0]        cand_pwr;
   logic [IDX_W-1:0]     cand_idx;

   // Sign-extend before multiplying so the full product is kept.
   assign re_x = PW'(bus.in_re);
   assign im_x = PW'(bus.in_im);

   // Bin counter: sole source of bin indices; holds across gaps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            cnt <= '0;
      else if (bus.in_valid) cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
   end

   // Valid shift register; top stage is pwr_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe <= '0;
      else        vld_pipe <= {vld_pipe[STAGES-1:1], bus.in_valid};
   end
   assign bus.pwr_valid = vld_pipe[STAGES];

   // Stage 1: squares and tag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_re <= '0;
         prod_im <= '0;
         tag1    <= '0;
      end else if (bus.in_valid) begin
         prod_re <= re_x * re_x;
         prod_im <= im_x * im_x;
         tag1    <= '{idx: cnt, sop: (cnt == '0), eop: (cnt == LAST_IDX)};
      end
   end

   // Stage 2: sum. Both squares are non-negative and the worst case is
   // 2^(PW-1), so an unsigned PW-bit add never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.pwr_out <= '0;
         bus.bin_idx <= '0;
         bus.sop     <= 1'b0;
         bus.eop     <= 1'b0;
      end else begin
         if (vld_pipe[1]) begin
            bus.pwr_out <= $unsigned(prod_re) + $unsigned(prod_im);
            bus.bin_idx <= tag1.idx;
         end
         // Markers are gated so they never linger high across a gap.
         bus.sop <= vld_pipe[1] & tag1.sop;
         bus.eop <= vld_pipe[1] & tag1.eop;
      end
   end

   // Strict compare: a tie keeps the earlier (lower) index.
   assign take     = bus.pwr_out > max_pwr;
   assign cand_pwr = take ? bus.pwr_out : max_pwr;
   assign cand_idx = take ? bus.bin_idx : max_idx;

   // Peak FSM. The report is registered on the eop edge so peak_valid is
   // high during the REPORT cycle; a new frame's sop in that same cycle
   // is loaded directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         max_pwr        <= '0;
         max_idx        <= '0;
         bus.peak_idx   <= '0;
         bus.peak_pwr   <= '0;
         bus.peak_valid <= 1'b0;
      end else begin
         bus.peak_valid <= 1'b0;
         case (state)
            IDLE, REPORT: begin
               state <= IDLE;
               if (bus.pwr_valid && bus.sop) begin
                  max_pwr <= bus.pwr_out;
                  max_idx <= bus.bin_idx;
                  state   <= ACCUM;
               end
            end
            ACCUM: begin
               if (bus.pwr_valid) begin
                  max_pwr <= cand_pwr;
                  max_idx <= cand_idx;
                  if (bus.eop) begin
                     bus.peak_pwr   <= cand_pwr;
                     bus.peak_idx   <= cand_idx;
                     bus.peak_valid <= 1'b1;
                     state          <= REPORT;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fft_bin_power_peak.sv
module tb_fft_bin_power_peak;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   last_cyc = 0;
   int   n_pass = 0;
   int   n_tot = 0;

   fft_bin_power_peak_if #(.DATA_WIDTH(16), .FFT_LENGTH(16)) bus ();

   fft_bin_power_peak #(.DATA_WIDTH(16), .FFT_LENGTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [31:0] pwr;
      logic [3:0]  idx;
      logic        sop;
      logic        eop;
      int          cyc;
   } pexp_t;

   typedef struct {
      logic [3:0]  idx;
      logic [31:0] pwr;
      int          cyc;
   } kexp_t;

   pexp_t pq[$];
   kexp_t kq[$];

   function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
   endfunction

   // Monitor: compares every presented output against the scoreboard head.
   always @(negedge clk) begin
      pexp_t e;
      kexp_t k;
      while (pq.size() > 0 && pq[0].cyc < cyc) begin
         n_tot++;
         $display("FAIL pwr_missing bin=%0d expected at cycle %0d, now %0d", pq[0].idx, pq[0].cyc, cyc);
         void'(pq.pop_front());
      end
      while (kq.size() > 0 && kq[0].cyc < cyc) begin
         n_tot++;
         $display("FAIL peak_missing idx=%0d expected at cycle %0d, now %0d", kq[0].idx, kq[0].cyc, cyc);
         void'(kq.pop_front());
      end
      if (bus.pwr_valid) begin
         if (pq.size() == 0) begin
            n_tot++;
            $display("FAIL pwr_unexpected got bin=%0d pwr=%h, required none", bus.bin_idx, bus.pwr_out);
         end else begin
            e = pq.pop_front();
            chk("pwr_data", {26'd0, bus.pwr_out, bus.bin_idx, bus.sop, bus.eop},
                            {26'd0, e.pwr, e.idx, e.sop, e.eop});
            chk("pwr_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      if (bus.peak_valid) begin
         if (kq.size() == 0) begin
            n_tot++;
            $display("FAIL peak_unexpected got idx=%0d pwr=%h, required none", bus.peak_idx, bus.peak_pwr);
         end else begin
            k = kq.pop_front();
            chk("peak_data", {28'd0, bus.peak_idx, bus.peak_pwr}, {28'd0, k.idx, k.pwr});
            chk("peak_cycle", 64'(cyc), 64'(k.cyc));
         end
      end
   end

   task automatic send(input logic signed [15:0] re, input logic signed [15:0] im,
                       input logic [3:0] k, input logic [31:0] epwr, input bit expect_out);
      pexp_t e;
      @(negedge clk);
      bus.in_re    = re;
      bus.in_im    = im;
      bus.in_valid = 1'b1;
      last_cyc     = cyc;
      if (expect_out) begin
         e.pwr = epwr;
         e.idx = k;
         e.sop = (k == 4'd0);
         e.eop = (k == 4'd15);
         e.cyc = cyc + 2;
         pq.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.in_re    = '0;
         bus.in_im    = '0;
      end
   endtask

   task automatic expect_peak(input logic [3:0] idx, input logic [31:0] pwr);
      kexp_t k;
      k.idx = idx;
      k.pwr = pwr;
      k.cyc = last_cyc + 3;
      kq.push_back(k);
   endtask

   task automatic ramp(input bit gapped);
      for (int k = 0; k < 16; k++) begin
         send(16'(k), 16'(k), 4'(k), 32'(2*k*k), 1'b1);
         if (gapped) idle(1);
      end
      expect_peak(4'd15, 32'd450);
   endtask

   function automatic logic [63:0] all_outs();
      return {bus.pwr_valid, bus.sop, bus.eop, bus.peak_valid, bus.bin_idx,
              bus.peak_idx, bus.pwr_out[23:0], bus.peak_pwr[23:0]} |
             {32'd0, bus.pwr_out[31:24], bus.peak_pwr[31:24], 16'd0};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish by time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic signed [15:0] re, im;
      logic [31:0]        p;
      bus.in_re    = '0;
      bus.in_im    = '0;
      bus.in_valid = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", all_outs(), 64'd0);
      rst_n = 1'b1;
      idle(2);

      // Ramp frame
      ramp(1'b0);
      idle(5);

      // Extremes: most-negative square at bin 5, max-positive real at bin 9
      for (int k = 0; k < 16; k++) begin
         re = (k == 5) ? 16'sh8000 : (k == 9) ? 16'sh7FFF : 16'sh0000;
         im = (k == 5) ? 16'sh8000 : 16'sh0000;
         p  = (k == 5) ? 32'h8000_0000 : (k == 9) ? 32'h3FFF_0001 : 32'h0;
         send(re, im, 4'(k), p, 1'b1);
      end
      expect_peak(4'd5, 32'h8000_0000);
      idle(5);

      // Ties: every bin 25, lowest index wins
      for (int k = 0; k < 16; k++) send(16'sd3, -16'sd4, 4'(k), 32'd25, 1'b1);
      expect_peak(4'd0, 32'd25);
      idle(5);

      // Gapped ramp
      ramp(1'b1);
      idle(5);

      // Back-to-back frames A and B
      for (int k = 0; k < 16; k++)
         send((k == 3) ? 16'sd100 : 16'sd0, 16'sd0, 4'(k), (k == 3) ? 32'd10000 : 32'd0, 1'b1);
      expect_peak(4'd3, 32'd10000);
      for (int k = 0; k < 16; k++)
         send(16'sd0, (k == 12) ? 16'sd200 : 16'sd0, 4'(k), (k == 12) ? 32'd40000 : 32'd0, 1'b1);
      expect_peak(4'd12, 32'd40000);
      idle(5);

      // Reset mid-frame: 7 bins in, only bins 0..4 reach the output first
      for (int k = 0; k < 7; k++) send(16'(k), 16'(k), 4'(k), 32'(2*k*k), k < 5);
      @(posedge clk);
      #1;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("midreset_outputs", all_outs(), 64'd0);
      rst_n = 1'b1;
      idle(1);
      ramp(1'b0);
      idle(6);

      chk("pwr_queue_empty", 64'(pq.size()), 64'd0);
      chk("peak_queue_empty", 64'(kq.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/fft_bin_power_peak.md
Name: fft_bin_power_peak

Overview:
Streaming post-processor placed directly downstream of the FFT output reorder stage. It consumes the natural-order serial bin stream (one complex sample per valid cycle) and emits per-bin power |X|^2 = re^2 + im^2 tagged with the bin index and frame markers. At the end of each frame it reports the peak bin index and its power. There is no backpressure, and input gaps are allowed.

Parameters:
DATA_WIDTH, 16, width of each signed two's-complement input component.
FFT_LENGTH, 16, bins per frame; must be a power of two and at least 4. Local IDX_W = log2(FFT_LENGTH).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_re  input  DATA_WIDTH  bin real part, signed.
in_im  input  DATA_WIDTH  bin imaginary part, signed.
in_valid  input  1  in_re/in_im hold a bin this cycle.
pwr_out  output  2*DATA_WIDTH  unsigned re^2+im^2.
pwr_valid  output  1  pwr_out/bin_idx/sop/eop valid.
bin_idx  output  IDX_W  bin index of pwr_out.
sop  output  1  first bin of frame (bin_idx==0), qualified by pwr_valid.
eop  output  1  last bin of frame (bin_idx==FFT_LENGTH-1), qualified by pwr_valid.
peak_idx  output  IDX_W  bin index of the maximum power in the last completed frame.
peak_pwr  output  2*DATA_WIDTH  power of that bin.
peak_valid  output  1  one-cycle pulse when peak_idx/peak_pwr update.

Behaviour:
- Reset (async assert, sync release): every output is 0. Bin counter is 0, FSM is IDLE, and the pipeline valids are cleared.
- Input counter: increments on every in_valid cycle and wraps from FFT_LENGTH-1 to 0. It holds during gaps. It is the sole source of bin_idx.
- Pipeline has 2 stages. Stage 1 registers the signed products re*re and im*im, each 2*DATA_WIDTH wide. Stage 2 registers the unsigned sum.
- pwr_valid is asserted exactly 2 cycles after the corresponding in_valid. bin_idx, sop and eop are delayed in lockstep with the data.
- Width rule: the maximum sum is 2*(2^(DATA_WIDTH-1))^2 = 2^(2*DATA_WIDTH-1). It fits in 2*DATA_WIDTH unsigned bits, so there is no saturation and no wrap.
- FSM states: IDLE, ACCUM, REPORT.
  - IDLE -> ACCUM when pwr_valid and sop. The running max loads this bin unconditionally.
  - ACCUM: on each pwr_valid, replace the running max only if pwr_out > max (strict). On a tie the lower index wins. On eop, the final compare includes the eop bin, then go to REPORT.
  - REPORT lasts one cycle. It copies the running max to peak_idx/peak_pwr, pulses peak_valid, then goes to IDLE.
  - If pwr_valid with sop arrives in the REPORT cycle (back-to-back frames), the new frame's load happens in that same cycle and the next state is ACCUM. Reporting the old frame is unaffected.
- peak_valid therefore rises 1 cycle after the eop output, which is 3 cycles after the last input bin.
- peak_idx/peak_pwr hold between reports.
- Reset mid-frame: the partial frame is discarded and no peak is reported for it. The next valid input is bin 0.
- in_valid gaps of any length inside a frame are allowed. Output cadence mirrors input cadence, delayed by 2 cycles.
- FFT_LENGTH=16 and DATA_WIDTH=16 are the values verified by the default bench.

Test Plan:
- Ramp frame: 16 consecutive valid cycles with in_re=in_im=k for k=0..15 -> pwr_out=2*k^2 (0,2,8,...,450). sop on bin 0, eop on bin 15. peak_valid pulses 3 cycles after the last input with peak_idx=15 and peak_pwr=450.
- Extremes: a bin with re=im=-32768 (0x8000) at bin 5 in an otherwise zero frame -> pwr_out=0x80000000 at bin 5; peak_idx=5, peak_pwr=0x80000000. A bin with re=32767, im=0 gives 0x3FFF0001.
- Ties: all 16 bins re=3, im=-4 -> every pwr_out=25; peak_idx=0, peak_pwr=25.
- Gapped input: ramp frame with in_valid low on alternate cycles -> identical pwr_out/bin_idx sequence, each output 2 cycles after its input; same peak result as the ramp frame.
- Back-to-back frames: frame A peak at bin 3 (re=100, im=0), then frame B immediately with peak at bin 12 (re=0, im=200) -> two peak_valid pulses, 16 cycles apart. The first reports idx 3, pwr 10000; the second reports idx 12, pwr 40000. sop of B coincides with REPORT of A.
- Reset mid-frame: assert rst_n low after 7 bins for 2 cycles -> all outputs 0 and no peak_valid. A following full ramp frame starts at bin_idx 0 and reports peak_idx=15, peak_pwr=450.
